// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// and a saturating count of the load-use bubbles it has inserted.
package idex_pkg;

  typedef struct packed {
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       alusrc;
    logic [3:0] aluop;
  } ctrl_t;

  typedef enum logic [1:0] {
    NEXT_LOAD,
    NEXT_HOLD,
    NEXT_FLUSH,
    NEXT_INSERT
  } next_e;

endpackage

module idex_stage
  import idex_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [3:0]        id_rs,
  input  logic [3:0]        id_rt,
  input  logic [3:0]        id_dst,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc2,
  input  logic [8:0]        id_ctrl,
  input  logic              flush,
  input  logic              ext_stall,
  output logic              ex_valid,
  output logic [3:0]        ex_rs,
  output logic [3:0]        ex_rt,
  output logic [3:0]        ex_dst,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc2,
  output logic [8:0]        ex_ctrl,
  output logic              load_use_stall,
  output logic [15:0]       stall_cnt
);

  typedef struct packed {
    logic              valid;
    logic [3:0]        rs;
    logic [3:0]        rt;
    logic [3:0]        dst;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc2;
    ctrl_t             ctrl;
  } stage_t;

  stage_t      cur_q;
  stage_t      nxt;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  next_e       sel;
  ctrl_t       id_c;
  logic        rs_hit;
  logic        rt_hit;

  assign id_c = ctrl_t'(id_ctrl);

  // A store's rt is only store data, which MEM-MEM forwarding supplies in time.
  assign rs_hit = id_uses_rs && (cur_q.dst == id_rs);
  assign rt_hit = id_uses_rt && !id_c.memwrite && (cur_q.dst == id_rt);

  assign load_use_stall = id_valid && cur_q.valid && cur_q.ctrl.memread &&
                          (cur_q.dst != 4'd0) && !flush && (rs_hit || rt_hit);

  always_comb begin
    if (flush)               sel = NEXT_FLUSH;
    else if (ext_stall)      sel = NEXT_HOLD;
    else if (load_use_stall) sel = NEXT_INSERT;
    else                     sel = NEXT_LOAD;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    nxt   = cur_q;
    cnt_d = cnt_q;
    unique case (sel)
      NEXT_FLUSH: nxt = '0;
      NEXT_HOLD:  nxt = cur_q;
      NEXT_INSERT: begin
        nxt   = '0;
        cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
      end
      NEXT_LOAD: begin
        nxt.valid   = id_valid;
        nxt.rs      = id_rs;
        nxt.rt      = id_rt;
        nxt.dst     = id_dst;
        nxt.rs_data = id_rs_data;
        nxt.rt_data = id_rt_data;
        nxt.imm     = id_imm;
        nxt.pc2     = id_pc2;
        // An empty slot must never enable a register or memory write.
        nxt.ctrl    = id_valid ? id_c : '0;
      end
      default: nxt = cur_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the async reset clears them without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q <= '0;
      cnt_q <= '0;
    end else begin
      cur_q <= nxt;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid   = cur_q.valid;
  assign ex_rs      = cur_q.rs;
  assign ex_rt      = cur_q.rt;
  assign ex_dst     = cur_q.dst;
  assign ex_rs_data = cur_q.rs_data;
  assign ex_rt_data = cur_q.rt_data;
  assign ex_imm     = cur_q.imm;
  assign ex_pc2     = cur_q.pc2;
  assign ex_ctrl    = cur_q.ctrl;
  assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_idex_stage.sv
// Directed bench for idex_stage: a table of instruction vectors plus
// hand-written ext_stall, saturation and asynchronous-reset sequences.
module tb_idex_stage;

  localparam logic [8:0] C_LW  = 9'h1B0;  // regwrite memread memtoreg alusrc
  localparam logic [8:0] C_ADD = 9'h102;  // regwrite, aluop=2
  localparam logic [8:0] C_SW  = 9'h050;  // memwrite alusrc

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_uses_rs, id_uses_rt, flush, ext_stall;
  logic [3:0]  id_rs, id_rt, id_dst;
  logic [15:0] id_rs_data, id_rt_data, id_imm, id_pc2;
  logic [8:0]  id_ctrl;
  logic        ex_valid, load_use_stall;
  logic [3:0]  ex_rs, ex_rt, ex_dst;
  logic [15:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc2, stall_cnt;
  logic [8:0]  ex_ctrl;

  int total = 0;
  int bad   = 0;

  idex_stage #(.DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_dst(id_dst), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_pc2(id_pc2), .id_ctrl(id_ctrl), .flush(flush), .ext_stall(ext_stall),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_pc2(ex_pc2), .ex_ctrl(ex_ctrl), .load_use_stall(load_use_stall),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef enum {K_LOAD, K_BUBBLE} kind_e;

  typedef struct {
    logic       valid;
    logic [3:0] rs;
    logic [3:0] rt;
    logic [3:0] dst;
    logic       urs;
    logic       urt;
    logic [8:0] ctrl;
    logic       fl;
    logic       exp_stall;
    kind_e      kind;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                              input logic [3:0] dst, input logic urs, input logic urt,
                              input logic [8:0] ctrl, input logic fl, input logic st,
                              input kind_e k, input logic [15:0] cnt);
    vec_t r;
    r.valid = v; r.rs = rs; r.rt = rt; r.dst = dst; r.urs = urs; r.urt = urt;
    r.ctrl = ctrl; r.fl = fl; r.exp_stall = st; r.kind = k; r.exp_cnt = cnt;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int seed);
    id_valid   = v.valid;
    id_rs      = v.rs;
    id_rt      = v.rt;
    id_dst     = v.dst;
    id_uses_rs = v.urs;
    id_uses_rt = v.urt;
    id_ctrl    = v.ctrl;
    flush      = v.fl;
    ext_stall  = 1'b0;
    id_rs_data = 16'(32'h1000 + seed);
    id_rt_data = 16'(32'h2000 + seed);
    id_imm     = 16'(32'h0040 + seed);
    id_pc2     = 16'(32'h0100 + 2 * seed);
  endtask

  task automatic check_ex(input string tag, input kind_e k, input vec_t v, input int seed);
    if (k == K_LOAD) begin
      check({tag, ".valid"},   32'(ex_valid),   32'(v.valid));
      check({tag, ".ctrl"},    32'(ex_ctrl),    v.valid ? 32'(v.ctrl) : 32'd0);
      check({tag, ".dst"},     32'(ex_dst),     32'(v.dst));
      check({tag, ".rs"},      32'(ex_rs),      32'(v.rs));
      check({tag, ".rt"},      32'(ex_rt),      32'(v.rt));
      check({tag, ".rs_data"}, 32'(ex_rs_data), 32'(16'(32'h1000 + seed)));
      check({tag, ".rt_data"}, 32'(ex_rt_data), 32'(16'(32'h2000 + seed)));
      check({tag, ".imm"},     32'(ex_imm),     32'(16'(32'h0040 + seed)));
      check({tag, ".pc2"},     32'(ex_pc2),     32'(16'(32'h0100 + 2 * seed)));
    end else begin
      check({tag, ".valid"},   32'(ex_valid),   32'd0);
      check({tag, ".ctrl"},    32'(ex_ctrl),    32'd0);
      check({tag, ".dst"},     32'(ex_dst),     32'd0);
      check({tag, ".rs"},      32'(ex_rs),      32'd0);
      check({tag, ".rt"},      32'(ex_rt),      32'd0);
      check({tag, ".rs_data"}, 32'(ex_rs_data), 32'd0);
      check({tag, ".rt_data"}, 32'(ex_rt_data), 32'd0);
      check({tag, ".imm"},     32'(ex_imm),     32'd0);
      check({tag, ".pc2"},     32'(ex_pc2),     32'd0);
    end
  endtask

  initial begin
    vec_t lw3, add_dep, nop;
    logic [15:0] sat_exp [3];

    lw3     = mk(1'b1, 4'd1, 4'd3, 4'd3, 1'b1, 1'b0, C_LW,  1'b0, 1'b0, K_LOAD, 16'd0);
    add_dep = mk(1'b1, 4'd3, 4'd4, 4'd5, 1'b1, 1'b1, C_ADD, 1'b0, 1'b0, K_LOAD, 16'd0);
    nop     = mk(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 9'd0,  1'b0, 1'b0, K_LOAD, 16'd0);

    vecs[0]  = mk(1, 4'd1, 4'd3, 4'd3, 1, 0, C_LW,  0, 0, K_LOAD,   16'd0);
    vecs[1]  = mk(1, 4'd3, 4'd4, 4'd5, 1, 1, C_ADD, 0, 1, K_BUBBLE, 16'd1);
    vecs[2]  = mk(1, 4'd3, 4'd4, 4'd5, 1, 1, C_ADD, 0, 0, K_LOAD,   16'd1);
    vecs[3]  = mk(1, 4'd1, 4'd3, 4'd3, 1, 0, C_LW,  0, 0, K_LOAD,   16'd1);
    vecs[4]  = mk(1, 4'd5, 4'd3, 4'd0, 1, 1, C_SW,  0, 0, K_LOAD,   16'd1);
    vecs[5]  = mk(1, 4'd1, 4'd0, 4'd0, 1, 0, C_LW,  0, 0, K_LOAD,   16'd1);
    vecs[6]  = mk(1, 4'd0, 4'd0, 4'd7, 1, 1, C_ADD, 0, 0, K_LOAD,   16'd1);
    vecs[7]  = mk(1, 4'd1, 4'd3, 4'd3, 1, 0, C_LW,  0, 0, K_LOAD,   16'd1);
    vecs[8]  = mk(1, 4'd3, 4'd4, 4'd5, 1, 1, C_ADD, 1, 0, K_BUBBLE, 16'd1);
    vecs[9]  = mk(1, 4'd1, 4'd3, 4'd3, 1, 0, C_LW,  0, 0, K_LOAD,   16'd1);
    vecs[10] = mk(1, 4'd2, 4'd3, 4'd6, 1, 1, C_ADD, 0, 1, K_BUBBLE, 16'd2);
    vecs[11] = mk(0, 4'd3, 4'd4, 4'd9, 1, 1, C_ADD, 0, 0, K_LOAD,   16'd2);
    vecs[12] = mk(1, 4'd1, 4'd3, 4'd3, 1, 0, C_LW,  0, 0, K_LOAD,   16'd2);
    vecs[13] = mk(1, 4'd3, 4'd3, 4'd6, 0, 0, C_ADD, 0, 0, K_LOAD,   16'd2);
    vecs[14] = mk(1, 4'd1, 4'd3, 4'd3, 1, 0, C_LW,  0, 0, K_LOAD,   16'd2);
    vecs[15] = mk(0, 4'd3, 4'd4, 4'd8, 1, 1, C_ADD, 0, 0, K_LOAD,   16'd2);

    // Reset state, with a would-be hazard on the id_* inputs.
    rst_n = 1'b0;
    apply(add_dep, 0);
    #12;
    check("reset.stall", 32'(load_use_stall), 32'd0);
    check("reset.cnt",   32'(stall_cnt),      32'd0);
    check_ex("reset", K_BUBBLE, nop, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      apply(vecs[i], i);
      #1;
      check($sformatf("v%0d.stall", i), 32'(load_use_stall), 32'(vecs[i].exp_stall));
      @(posedge clk);
      #1;
      check_ex($sformatf("v%0d", i), vecs[i].kind, vecs[i], i);
      check($sformatf("v%0d.cnt", i), 32'(stall_cnt), 32'(vecs[i].exp_cnt));
    end

    // ext_stall freezes a load in EX while id_* keeps changing.
    @(negedge clk);
    apply(lw3, 100);
    @(posedge clk);
    #1;
    check_ex("es.lw", K_LOAD, lw3, 100);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      apply(add_dep, 101 + c);
      ext_stall = 1'b1;
      @(posedge clk);
      #1;
      check_ex($sformatf("es.hold%0d", c), K_LOAD, lw3, 100);
      check($sformatf("es.hold%0d.cnt", c), 32'(stall_cnt), 32'd2);
    end
    @(negedge clk);
    apply(add_dep, 110);
    #1;
    check("es.rel.stall", 32'(load_use_stall), 32'd1);
    @(posedge clk);
    #1;
    check_ex("es.rel", K_BUBBLE, nop, 0);
    check("es.rel.cnt", 32'(stall_cnt), 32'd3);
    @(negedge clk);
    apply(add_dep, 111);
    #1;
    check("es.replay.stall", 32'(load_use_stall), 32'd0);
    @(posedge clk);
    #1;
    check_ex("es.replay", K_LOAD, add_dep, 111);
    check("es.replay.cnt", 32'(stall_cnt), 32'd3);

    // Saturation: preset the counter near the top, then stall three times.
    @(negedge clk);
    force dut.cnt_q = 16'hFFFD;
    #1;
    release dut.cnt_q;
    sat_exp[0] = 16'hFFFE;
    sat_exp[1] = 16'hFFFF;
    sat_exp[2] = 16'hFFFF;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      apply(lw3, 120 + s);
      @(negedge clk);
      apply(add_dep, 130 + s);
      #1;
      check($sformatf("sat%0d.stall", s), 32'(load_use_stall), 32'd1);
      @(posedge clk);
      #1;
      check($sformatf("sat%0d.cnt", s), 32'(stall_cnt), 32'(sat_exp[s]));
    end

    // Asynchronous reset mid-stall, away from any clock edge.
    @(negedge clk);
    apply(lw3, 140);
    @(negedge clk);
    apply(add_dep, 141);
    #1;
    check("ar.pre.stall", 32'(load_use_stall), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar.stall", 32'(load_use_stall), 32'd0);
    check("ar.cnt",   32'(stall_cnt),      32'd0);
    check_ex("ar", K_BUBBLE, nop, 0);

    // First edge after reset release is a normal load.
    @(negedge clk);
    apply(add_dep, 150);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_ex("post", K_LOAD, add_dep, 150);
    check("post.cnt", 32'(stall_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
